decode_scoreboard: RTL

DECODE_SCOREBOARD -- requirements
Module: decode_scoreboard

---
 rtl/decode_scoreboard_pkg.sv | 23 ++
 rtl/decode_scoreboard_if.sv | 34 +++
 rtl/decode_scoreboard_sb_counter.sv | 48 ++++
 rtl/decode_scoreboard.sv | 126 ++++++++++++
 4 files changed

// File: rtl/decode_scoreboard_pkg.sv
// Shared types for the decode scoreboard: register address type, register count
// and the run/flush state encoding.
package decode_scoreboard_pkg;

  localparam int NREG   = 32;
  localparam int CREG_W = $clog2(NREG);

  typedef logic [CREG_W-1:0] creg_addr_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } sb_state_e;

  localparam logic [0:0] ST_RUN   = RUN;
  localparam logic [0:0] ST_FLUSH = FLUSH;

  // Register 0 is hardwired to zero, so it never carries a dependency.
  function automatic logic addr_live(input creg_addr_t a);
    return (a != {CREG_W{1'b0}});
  endfunction

endpackage

// File: rtl/decode_scoreboard_if.sv
// Issue / write-back / status bundle between decode (master) and the scoreboard (slave).
interface decode_scoreboard_if #(
  parameter int NREG = decode_scoreboard_pkg::NREG
);
  import decode_scoreboard_pkg::*;

  logic            iss_valid;
  creg_addr_t      iss_ra1;
  creg_addr_t      iss_ra2;
  logic            iss_use1;
  logic            iss_use2;
  logic            iss_wen;
  creg_addr_t      iss_rdst;
  logic            iss_ready;
  logic            wb_valid;
  creg_addr_t      wb_rdst;
  logic            flush;
  logic [NREG-1:0] busy_mask;
  logic [31:0]     stall_cnt;
  logic            err_underflow;

  modport master (
    output iss_valid, iss_ra1, iss_ra2, iss_use1, iss_use2, iss_wen, iss_rdst,
    output wb_valid, wb_rdst, flush,
    input  iss_ready, busy_mask, stall_cnt, err_underflow
  );

  modport slave (
    input  iss_valid, iss_ra1, iss_ra2, iss_use1, iss_use2, iss_wen, iss_rdst,
    input  wb_valid, wb_rdst, flush,
    output iss_ready, busy_mask, stall_cnt, err_underflow
  );

endinterface

// File: rtl/decode_scoreboard_sb_counter.sv
// One pending-write counter: saturating up/down with synchronous clear.
// Simultaneous inc and dec cancel; dec at zero holds zero and flags underflow.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;

  // next-count selection
  always_comb begin
    count_nxt_s = count_r;
    if (clr) begin
      count_nxt_s = CNT_ZERO;
    end else if (inc && !dec) begin
      count_nxt_s = (count_r == CNT_MAX) ? CNT_MAX : count_r + CNT_ONE;
    end else if (dec && !inc) begin
      count_nxt_s = (count_r == CNT_ZERO) ? CNT_ZERO : count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // count register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= CNT_ZERO;
    end else begin
      count_r <= count_nxt_s;
    end
  end

  assign count     = count_r;
  assign underflow = dec && !clr && (count_r == CNT_ZERO);

endmodule

// File: rtl/decode_scoreboard.sv
// Register-dependency scoreboard beside decode: per-register pending-write counts,
// RAW/overflow hazard detection with write-back bypass, and a one-cycle flush state.
module decode_scoreboard #(
  parameter int NREG  = decode_scoreboard_pkg::NREG,
  parameter int CNT_W = 2
) (
  input logic               clk,
  input logic               reset,
  decode_scoreboard_if.slave sb
);
  import decode_scoreboard_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_s [NREG];
  logic [NREG-1:1]  uflow_s;
  logic [NREG-1:0]  busy_s;
  logic [0:0]       state_r;
  logic [0:0]       state_nxt_s;
  logic [31:0]      stall_cnt_r;
  logic             err_underflow_r;
  logic             src1_haz_s;
  logic             src2_haz_s;
  logic             dst_haz_s;
  logic             ready_s;
  logic             issue_s;
  logic             wb_live_s;

  assign cnt_s[0] = CNT_ZERO;

  // write-backs are dropped while flushing or in the flush state
  assign wb_live_s = sb.wb_valid && (state_r == ST_RUN) && !sb.flush;
  assign issue_s   = sb.iss_valid && ready_s;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    logic inc_s;
    logic dec_s;
    assign inc_s = issue_s && sb.iss_wen && (sb.iss_rdst == creg_addr_t'(r));
    assign dec_s = wb_live_s && (sb.wb_rdst == creg_addr_t'(r));
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .clr       (sb.flush),
      .inc       (inc_s),
      .dec       (dec_s),
      .count     (cnt_s[r]),
      .underflow (uflow_s[r])
    );
  end

  // source and destination hazard detection
  always_comb begin
    src1_haz_s = 1'b0;
    src2_haz_s = 1'b0;
    dst_haz_s  = 1'b0;
    if (sb.iss_use1 && addr_live(sb.iss_ra1) && (cnt_s[sb.iss_ra1] != CNT_ZERO)) begin
      src1_haz_s = !((cnt_s[sb.iss_ra1] == CNT_ONE) && sb.wb_valid && (sb.wb_rdst == sb.iss_ra1));
    end else begin
      src1_haz_s = 1'b0;
    end
    if (sb.iss_use2 && addr_live(sb.iss_ra2) && (cnt_s[sb.iss_ra2] != CNT_ZERO)) begin
      src2_haz_s = !((cnt_s[sb.iss_ra2] == CNT_ONE) && sb.wb_valid && (sb.wb_rdst == sb.iss_ra2));
    end else begin
      src2_haz_s = 1'b0;
    end
    // a same-cycle write-back does not relieve a saturated destination
    if (sb.iss_wen && addr_live(sb.iss_rdst) && (cnt_s[sb.iss_rdst] == CNT_MAX)) begin
      dst_haz_s = 1'b1;
    end else begin
      dst_haz_s = 1'b0;
    end
  end

  assign ready_s = reset && !sb.flush && (state_r == ST_RUN)
                   && !src1_haz_s && !src2_haz_s && !dst_haz_s;

  // run/flush next state
  always_comb begin
    state_nxt_s = ST_RUN;
    case (state_r)
      ST_RUN:   state_nxt_s = sb.flush ? ST_FLUSH : ST_RUN;
      ST_FLUSH: state_nxt_s = sb.flush ? ST_FLUSH : ST_RUN;
      default:  state_nxt_s = ST_RUN;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // stall counter and sticky underflow flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r     <= 32'd0;
      err_underflow_r <= 1'b0;
    end else begin
      if (sb.iss_valid && !ready_s) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end
      if (|uflow_s) begin
        err_underflow_r <= 1'b1;
      end
    end
  end

  // busy bit per register
  always_comb begin
    busy_s = {NREG{1'b0}};
    for (int i = 0; i < NREG; i++) begin
      busy_s[i] = (cnt_s[i] != CNT_ZERO);
    end
  end

  assign sb.iss_ready     = ready_s;
  assign sb.busy_mask     = busy_s;
  assign sb.stall_cnt     = stall_cnt_r;
  assign sb.err_underflow = err_underflow_r;

endmodule
